// File: rtl/fetch_pkg.sv
// Shared state type and constants for the instruction-fetch stage.
// Imported by fetch_if, fetch_perf_ctr and fetch_stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [15:0] DEF_NOP_INSTR   = 16'h0000;
  localparam logic [3:0]  DEF_HALT_OPCODE = 4'hF;

  // Opcode field position inside a 16-bit instruction word.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  localparam int PERF_W = 16;

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage and its environment (imem, hazard unit, IF/ID).
// Build option FETCH_PERF_EN adds the fetch/bubble performance counters.
interface fetch_if import fetch_pkg::*; #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) ();

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc_out;
  logic               halted;

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0]  fetch_count;
  logic [PERF_W-1:0]  bubble_count;

  modport master (
    output imem_addr, instruction, pc_out, halted, fetch_count, bubble_count,
    input  imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, instruction, pc_out, halted, fetch_count, bubble_count,
    output imem_rdata, stall, branch_taken, branch_target
  );
`else
  modport master (
    output imem_addr, instruction, pc_out, halted,
    input  imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, instruction, pc_out, halted,
    output imem_rdata, stall, branch_taken, branch_target
  );
`endif

endinterface

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter used for fetch-stage performance statistics.
module fetch_perf_ctr import fetch_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  output logic [PERF_W-1:0] o_count
);

  logic [PERF_W-1:0] r_count;

  // Sticks at all-ones instead of wrapping so a long run never reads as short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + PERF_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handles redirects, stalls, boot and HALT.
// Build option FETCH_PERF_EN adds fetch_count/bubble_count on the bus.
module fetch_stage import fetch_pkg::*; #(
  parameter int                 PC_W        = 8,
  parameter int                 INSTR_W     = 16,
  parameter logic [PC_W-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = DEF_NOP_INSTR,
  parameter logic [3:0]         HALT_OPCODE = DEF_HALT_OPCODE
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master bus
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_halted;

  logic            w_fetchValid;
  logic            w_isHalt;

  // A real instruction leaves only in RUN with no redirect and no stall.
  assign w_fetchValid = (r_state == ST_RUN) && !bus.branch_taken && !bus.stall;
  assign w_isHalt     = (bus.imem_rdata[OPC_HI:OPC_LO] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.branch_taken) begin
            r_pc <= bus.branch_target;
          end else if (bus.stall) begin
            r_pc <= r_pc;
          end else if (w_isHalt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        ST_HALTED: begin
          // An older taken branch proves the HALT was on the wrong path.
          if (bus.branch_taken) begin
            r_pc     <= bus.branch_target;
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.pc_out      = r_pc;
  assign bus.halted      = r_halted;
  assign bus.instruction = w_fetchValid ? bus.imem_rdata : NOP_INSTR;

`ifdef FETCH_PERF_EN
  logic w_bubble;

  assign w_bubble = (r_state != ST_BOOT) && !w_fetchValid;

  fetch_perf_ctr u_fetchCtr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_fetchValid),
    .o_count (bus.fetch_count)
  );

  fetch_perf_ctr u_bubbleCtr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_bubble),
    .o_count (bus.bubble_count)
  );
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register; it produces the 16-bit instruction that register captures every clock.
- Owns the program counter, drives the instruction-memory address, and accepts branch redirects resolved downstream.
- Inserts NOP bubbles on stall, squash and boot.
- Small FSM handles boot and the HALT instruction.

Parameters:
- PC_W, 8, program-counter width in bits; word-addressed, one instruction per address.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 16'h0000, encoding presented when a bubble is inserted.
- HALT_OPCODE, 4'hF, value of instruction[15:12] that identifies HALT.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  PC_W  instruction-memory address; equals the PC register, combinational from state.
- imem_rdata  input  INSTR_W  instruction-memory data; asynchronous read, valid in the same cycle.
- stall  input  1  hazard-unit request to hold fetch for this cycle.
- branch_taken  input  1  downstream branch resolved taken this cycle.
- branch_target  input  PC_W  redirect address; sampled only when branch_taken=1.
- instruction  output  INSTR_W  instruction presented to the IF/ID register this cycle.
- pc_out  output  PC_W  PC of the instruction being presented (debug/link use).
- halted  output  1  high while in HALTED.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, any time, including mid-redirect):
  - PC=RESET_PC, state=BOOT.
  - Outputs during reset: instruction=NOP_INSTR, pc_out=RESET_PC, halted=0.
- States: BOOT, RUN, HALTED.
- BOOT:
  - Lasts exactly one cycle; instruction=NOP_INSTR; PC holds.
  - Next state is RUN.
  - A branch_taken asserted during BOOT is ignored.
- RUN, priority branch_taken > stall > normal:
  - branch_taken: PC<=branch_target; instruction=NOP_INSTR (wrong-path squash); stay RUN.
  - stall, no branch: PC holds; instruction=NOP_INSTR. The same address is re-presented the next cycle, because the IF/ID register has no enable.
  - normal, imem_rdata[15:12]!=HALT_OPCODE: instruction=imem_rdata; PC<=PC+1.
  - normal, HALT opcode: instruction=imem_rdata, so HALT propagates; PC holds; next state HALTED.
- HALTED:
  - instruction=NOP_INSTR; PC holds; halted=1; stall ignored.
  - branch_taken=1 means an older branch makes the HALT wrong-path: PC<=branch_target; next state RUN; instruction this cycle=NOP_INSTR.
- PC arithmetic: unsigned modulo 2^PC_W; PC=all-ones increments to 0 with no flag.
- pc_out:
  - equals the current PC whenever instruction comes from imem_rdata;
  - equals the current PC (don't-care for consumers) during bubbles.
- Latency:
  - address to instruction: 0 cycles (combinational);
  - branch_taken to first target instruction presented: 1 cycle.
- Simultaneous stall and branch_taken: the redirect wins and the stall is dropped.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined, two extra outputs are added:
  - fetch_count (16 bits): increments on each cycle a real instruction is presented.
  - bubble_count (16 bits): increments on each NOP_INSTR cycle after BOOT.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- Without the macro: no such ports and no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (BOOT, RUN, HALTED);
  - the NOP_INSTR and HALT_OPCODE default constants;
  - an opcode-field slice helper constant giving bits 15:12.
- One sub-module, fetch_perf_ctr: a saturating 16-bit counter with increment enable, instantiated twice under FETCH_PERF_EN.

Test Plan:
- Reset then release with memory holding 0x1234,0x2345 at addresses 0 and 1:
  - first cycle after release: instruction=0x0000, imem_addr=0;
  - then 0x1234 (pc_out=0);
  - then 0x2345 (pc_out=1).
- stall held 2 cycles at PC=5:
  - instruction=NOP both cycles, imem_addr stays 5;
  - cycle after release presents mem[5].
- branch_taken with branch_target=0x40 while stall=1 at PC=7:
  - instruction=NOP;
  - next cycle imem_addr=0x40 and instruction=mem[0x40].
- HALT word 0xF000 at address 3:
  - 0xF000 presented once;
  - halted=1 from next cycle, NOPs thereafter, PC stays 3;
  - then branch_taken to 0x10 clears halted and fetch resumes at 0x10.
- PC_W=8 wrap: sequential fetch from 0xFE presents 0xFE, 0xFF, then 0x00.
- Assert rst_n low mid-redirect (branch_taken=1 on the same edge):
  - PC=RESET_PC immediately, halted=0, instruction=NOP;
  - with FETCH_PERF_EN: counters read 0.
